rf_wport_arb: RTL and testbench
===============================

# rf_wport_arb

Write-port arbiter and sequencer for the 32x32 register file in the multicycle datapath. It shares the single RF write port between two requesters:
- primary: the main-FSM writeback stage (ALU, load, link results);
- secondary: a long-latency source such as the multiply/divide unit or the debug write path.

It registers the winning write onto the RF's `RegWr`/`wa_i`/`wd_i` inputs, drops writes to `$0`, and guarantees the secondary requester bounded wait through a starvation counter.

## Interface
- `DW`, 32, data width of write data
- `AW`, 5, register address width
- `STARVE_MAX`, 3, consecutive denied secondary cycles before priority flips (legal 1..15)

Ports (name, direction, width, meaning):
- `clk` input 1: system clock, all state on rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `p_req` input 1: primary write request
- `p_wa` input AW: primary destination register
- `p_wd` input DW: primary write data
- `p_gnt` output 1: primary grant (combinational)
- `s_req` input 1: secondary write request
- `s_wa` input AW: secondary destination register
- `s_wd` input DW: secondary write data
- `s_gnt` output 1: secondary grant (combinational)
- `RegWr` output 1: registered RF write enable
- `wa_o` output AW: registered RF write address
- `wd_o` output DW: registered RF write data
- `starved` output 1: registered, high while the FSM is in SEC_PRI

## Operation
- Handshake: a transfer occurs at a rising edge where `x_req && x_gnt`. Requesters hold `req`/`wa`/`wd` stable until granted. At most one grant per cycle; `p_gnt && s_gnt` is never 1.
- FSM has two states: `PRI_PRI` (reset state) and `SEC_PRI`.
  - `PRI_PRI`: `p_gnt = p_req`; `s_gnt = s_req && !p_req`.
  - `SEC_PRI`: `s_gnt = s_req`; `p_gnt = p_req && !s_req`.
- Starvation counter `cnt`, width 4:
  - In `PRI_PRI`: increments on each cycle with `s_req && !s_gnt`. Clears on a secondary transfer or on any cycle with `!s_req`.
  - When `cnt == STARVE_MAX-1` and the secondary is denied again, the next state is `SEC_PRI` and `cnt` clears.
- `SEC_PRI` returns to `PRI_PRI` after one secondary transfer, or immediately if `s_req` is low. At most one secondary write is forced per flip.
- Output register, on a transfer from requester x:
  - `wa_o <= x_wa`, `wd_o <= x_wd`;
  - `RegWr <= (x_wa != 0)`. A write to `$0` is accepted (granted) but suppressed.
  - With no transfer: `RegWr <= 0`, and `wa_o`/`wd_o` hold their last values.
- `starved` is the registered state bit (1 in `SEC_PRI`).

## Timing
- Reset values (async assert): `RegWr=0`, `wa_o=0`, `wd_o=0`, `starved=0`, state `PRI_PRI`, `cnt=0`.
- While `rst_n` is low, `p_gnt = s_gnt = 0`. Deassertion is synchronous to `clk` by the system reset synchronizer. Reset mid-transfer drops the pending output write: `RegWr` clears immediately.
- Latency, transfer at edge k:
  - `RegWr`/`wa_o`/`wd_o` are valid from edge k to edge k+1, a single-cycle pulse.
  - The RF latches on the falling edge inside that cycle, so the data is readable from the RF starting half a cycle after edge k.
- Throughput: one write per cycle. Back-to-back primary transfers produce continuous `RegWr=1` with updated address/data each cycle.
- Worst-case secondary wait with `p_req` held high: `STARVE_MAX` denied cycles, then granted in the next cycle.
- Both requesters targeting the same register: the writes are serialized. The later transfer overwrites the RF entry one cycle later.
- A request dropped before grant is legal and has no effect. `cnt` clears if it was `s_req`.

## Test plan
- Reset: assert `rst_n=0` mid-cycle with `p_req=1` -> `RegWr`, `wa_o`, `wd_o` = 0 at once and both grants 0. After release, the first edge with `p_req=1, p_wa=5, p_wd=32'h1234` -> `RegWr=1, wa_o=5, wd_o=32'h1234` for exactly one cycle.
- Primary only: 4 consecutive writes to r1..r4 with data 32'hA1..A4 -> `RegWr` high 4 cycles, address/data track each cycle, `s_gnt=0`.
- Starvation (`STARVE_MAX=3`): `p_req` and `s_req` held high with `s_wa=9`, `s_wd=32'hDEAD` ->
  - `s_gnt` low for 3 cycles, `starved=1` next;
  - secondary granted on cycle 4 with `wa_o=9`, then `PRI_PRI` resumes.
- Zero register: `p_wa=0`, `p_wd=32'hFFFF_FFFF` granted -> `p_gnt=1`, `RegWr` stays 0.
- Counter clear: `s_req` denied 2 cycles, dropped 1 cycle, re-asserted -> 3 further denials are needed before `starved=1`.

Source files
------------

// File: rtl/rf_wport_arb_if.sv
// Purpose: bundles both write requesters, their grants and the registered RF write port.
// Latency: pure wiring; grants are combinational, the RF write fields are registered in the arbiter.
// Backpressure: a requester holds req/wa/wd until it sees its grant high at a rising edge.
interface rf_wport_arb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  // primary requester (main-FSM writeback)
  logic          p_req;
  logic [AW-1:0] p_wa;
  logic [DW-1:0] p_wd;
  logic          p_gnt;
  // secondary requester (mul/div unit or debug write path)
  logic          s_req;
  logic [AW-1:0] s_wa;
  logic [DW-1:0] s_wd;
  logic          s_gnt;
  // registered register-file write port
  logic          RegWr;
  logic [AW-1:0] wa_o;
  logic [DW-1:0] wd_o;
  logic          starved;

  // arbiter side
  modport slave (
    input  p_req, p_wa, p_wd,
    input  s_req, s_wa, s_wd,
    output p_gnt, s_gnt,
    output RegWr, wa_o, wd_o, starved
  );

  // requester / register-file side
  modport master (
    output p_req, p_wa, p_wd,
    output s_req, s_wa, s_wd,
    input  p_gnt, s_gnt,
    input  RegWr, wa_o, wd_o, starved
  );
endinterface

// File: rtl/rf_wport_arb.sv
// Purpose: shares the single RF write port between primary and secondary requesters, drops $0 writes.
// Latency: transfer at edge k drives RegWr/wa_o/wd_o from edge k to k+1 (one-cycle write pulse).
// Backpressure: combinational grants; secondary waits at most STARVE_MAX denied cycles before winning.
module rf_wport_arb #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  rf_wport_arb_if.slave bus
);

  typedef enum logic {
    PRI_PRI = 1'b0,
    SEC_PRI = 1'b1
  } state_t;

  // Denial count at which the next denial flips priority to the secondary.
  localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;

  logic          w_p_gnt;
  logic          w_s_gnt;
  logic          w_p_xfer;
  logic          w_s_xfer;
  logic          w_s_denied;

  logic          w_any_xfer;
  logic [AW-1:0] w_sel_wa;
  logic [DW-1:0] w_sel_wd;

  logic          r_regwr;
  logic [AW-1:0] r_wa;
  logic [DW-1:0] r_wd;

  // Grants follow the current priority order; both are held low while reset is asserted.
  always_comb begin
    w_p_gnt = 1'b0;
    w_s_gnt = 1'b0;
    if (rst_n) begin
      if (r_state == SEC_PRI) begin
        w_s_gnt = bus.s_req;
        w_p_gnt = bus.p_req && !bus.s_req;
      end else begin
        w_p_gnt = bus.p_req;
        w_s_gnt = bus.s_req && !bus.p_req;
      end
    end
  end

  assign w_p_xfer   = bus.p_req && w_p_gnt;
  assign w_s_xfer   = bus.s_req && w_s_gnt;
  assign w_s_denied = bus.s_req && !w_s_gnt;

  // Next state and starvation count: count consecutive secondary denials, flip on the last one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 4'd0;
    case (r_state)
      PRI_PRI: begin
        // Any cycle without a denial (secondary idle or granted) restarts the count.
        if (w_s_denied) begin
          if (r_cnt >= CNT_LAST) begin
            w_state_nxt = SEC_PRI;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      SEC_PRI: begin
        // The secondary always wins here, so this cycle either carries its one forced
        // write or it has nothing pending; either way priority goes back to primary.
        w_state_nxt = PRI_PRI;
      end
      default: begin
        w_state_nxt = PRI_PRI;
      end
    endcase
  end

  // Priority state and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PRI_PRI;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Select the winning requester's address/data; grants are exclusive so order is irrelevant.
  always_comb begin
    w_any_xfer = w_p_xfer || w_s_xfer;
    w_sel_wa   = r_wa;
    w_sel_wd   = r_wd;
    if (w_p_xfer) begin
      w_sel_wa = bus.p_wa;
      w_sel_wd = bus.p_wd;
    end else if (w_s_xfer) begin
      w_sel_wa = bus.s_wa;
      w_sel_wd = bus.s_wd;
    end
  end

  // RF write port: one-cycle enable pulse per transfer, $0 accepted but never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwr <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
    end else begin
      r_regwr <= w_any_xfer && (w_sel_wa != '0);
      if (w_any_xfer) begin
        r_wa <= w_sel_wa;
        r_wd <= w_sel_wd;
      end
    end
  end

  assign bus.p_gnt   = w_p_gnt;
  assign bus.s_gnt   = w_s_gnt;
  assign bus.RegWr   = r_regwr;
  assign bus.wa_o    = r_wa;
  assign bus.wd_o    = r_wd;
  assign bus.starved = (r_state == SEC_PRI);

endmodule

// File: tb/tb_rf_wport_arb.sv
// Purpose: directed scoreboard bench for rf_wport_arb (reset, primary stream, starvation, $0, count clear).
// Latency: expected writes are queued at the negedge before the transfer edge and popped just after it.
// Backpressure: grants and the starved flag are compared every driven cycle against hand-derived values.
module tb_rf_wport_arb;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wr_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  wr_t  exp_q[$];

  rf_wport_arb_if #(.DW(DW), .AW(AW)) bus();

  rf_wport_arb #(
    .DW(DW),
    .AW(AW),
    .STARVE_MAX(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the negedge, check grants/starved, and queue the write the next edge must produce.
  task automatic cyc(input logic pr, input logic [AW-1:0] pwa, input logic [DW-1:0] pwd,
                     input logic sr, input logic [AW-1:0] swa, input logic [DW-1:0] swd,
                     input logic epg, input logic esg, input logic est, input string name);
    wr_t e;
    @(negedge clk);
    bus.p_req = pr;
    bus.p_wa  = pwa;
    bus.p_wd  = pwd;
    bus.s_req = sr;
    bus.s_wa  = swa;
    bus.s_wd  = swd;
    #1;
    chk({name, "_p_gnt"}, 64'(bus.p_gnt), 64'(epg));
    chk({name, "_s_gnt"}, 64'(bus.s_gnt), 64'(esg));
    chk({name, "_starved"}, 64'(bus.starved), 64'(est));
    if (epg && pr && pwa != '0) begin
      e.wa = pwa;
      e.wd = pwd;
      exp_q.push_back(e);
    end else if (esg && sr && swa != '0) begin
      e.wa = swa;
      e.wd = swd;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: after every rising edge, RegWr must be high exactly when a write is queued, with matching fields.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("regwr_pulse", 64'(bus.RegWr), 64'(exp_q.size() > 0));
      if (bus.RegWr === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_wa", 64'(bus.wa_o), 64'(e.wa));
        chk("write_wd", 64'(bus.wd_o), 64'(e.wd));
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.p_req = 1'b1;
    bus.p_wa  = 5'd7;
    bus.p_wd  = 32'h77;
    bus.s_req = 1'b1;
    bus.s_wa  = 5'd8;
    bus.s_wd  = 32'h88;

    // Held in reset with both requests up: no grants, cleared write port.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_p_gnt", 64'(bus.p_gnt), 64'd0);
    chk("rst_s_gnt", 64'(bus.s_gnt), 64'd0);
    chk("rst_regwr", 64'(bus.RegWr), 64'd0);
    chk("rst_wa", 64'(bus.wa_o), 64'd0);
    chk("rst_wd", 64'(bus.wd_o), 64'd0);
    chk("rst_starved", 64'(bus.starved), 64'd0);
    bus.p_req = 1'b0;
    bus.s_req = 1'b0;
    rst_n = 1'b1;

    // First write after release, then an idle cycle so the pulse must end.
    cyc(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0, 1, 0, 0, "first");
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, "idle0");

    // Reset asserted mid-cycle just after a transfer edge: the write pulse dies at once.
    cyc(1, 5'd6, 32'h5678, 0, 5'd0, 32'h0, 1, 0, 0, "pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_regwr", 64'(bus.RegWr), 64'd0);
    chk("midrst_wa", 64'(bus.wa_o), 64'd0);
    chk("midrst_wd", 64'(bus.wd_o), 64'd0);
    chk("midrst_p_gnt", 64'(bus.p_gnt), 64'd0);
    chk("midrst_s_gnt", 64'(bus.s_gnt), 64'd0);
    @(negedge clk);
    bus.p_req = 1'b0;
    rst_n = 1'b1;

    // Primary-only burst: back-to-back writes r1..r4.
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 5'(i), 32'hA0 + 32'(i), 0, 5'd0, 32'h0, 1, 0, 0, "prim_burst");
    end
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, "idle1");

    // Starvation: three denials, then the secondary is forced through once.
    cyc(1, 5'd11, 32'hB1, 1, 5'd9, 32'hDEAD, 1, 0, 0, "starve_d1");
    cyc(1, 5'd12, 32'hB2, 1, 5'd9, 32'hDEAD, 1, 0, 0, "starve_d2");
    cyc(1, 5'd13, 32'hB3, 1, 5'd9, 32'hDEAD, 1, 0, 0, "starve_d3");
    cyc(1, 5'd14, 32'hB4, 1, 5'd9, 32'hDEAD, 0, 1, 1, "starve_sec");
    cyc(1, 5'd14, 32'hB4, 0, 5'd9, 32'hDEAD, 1, 0, 0, "starve_back");
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, "idle2");

    // Write to $0: granted, no RF write, address/data still latched.
    cyc(1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0, 1, 0, 0, "zero_reg");
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, "idle3");
    chk("zero_regwr", 64'(bus.RegWr), 64'd0);
    chk("zero_wa", 64'(bus.wa_o), 64'd0);
    chk("zero_wd", 64'(bus.wd_o), 64'hFFFF_FFFF);

    // Dropping s_req clears the count: three fresh denials are needed again.
    cyc(1, 5'd20, 32'hC0, 1, 5'd17, 32'hBEEF, 1, 0, 0, "clr_d1");
    cyc(1, 5'd21, 32'hC1, 1, 5'd17, 32'hBEEF, 1, 0, 0, "clr_d2");
    cyc(1, 5'd22, 32'hC2, 0, 5'd17, 32'hBEEF, 1, 0, 0, "clr_drop");
    cyc(1, 5'd23, 32'hC3, 1, 5'd17, 32'hBEEF, 1, 0, 0, "clr_d3");
    cyc(1, 5'd24, 32'hC4, 1, 5'd17, 32'hBEEF, 1, 0, 0, "clr_d4");
    cyc(1, 5'd25, 32'hC5, 1, 5'd17, 32'hBEEF, 1, 0, 0, "clr_d5");
    cyc(1, 5'd26, 32'hC6, 1, 5'd17, 32'hBEEF, 0, 1, 1, "clr_sec");
    cyc(1, 5'd26, 32'hC6, 0, 5'd17, 32'hBEEF, 1, 0, 0, "clr_back");
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, "idle4");
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, "idle5");

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
